// File: rtl/sms_pkg.sv
// Shared definitions for the sms_inv_bank inverter/trigger bank.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package sms_pkg;

  // Per-channel operating mode, one bit per channel on the mode port.
  typedef enum logic {
    SMS_MODE_INV  = 1'b0,
    SMS_MODE_TRIG = 1'b1
  } sms_mode_e;

  // Deepest supported delay line; also sizes the fill counter.
  localparam int SMS_DELAY_MAX = 8;

  // Floating-input test: true only for a high-impedance bit.
  // The 0/1 exclusions come first so a two-state evaluation, where no
  // z can exist, folds to a plain false.
  function automatic logic is_z(input logic x);
    return (x !== 1'b0) && (x !== 1'b1) && (x === 1'bz);
  endfunction

  // Pull-up read of a gate input: 1 and z read as 1; 0 and x read as 0.
  function automatic logic ipu(input logic x);
    return (x === 1'b1) || is_z(x);
  endfunction

endpackage

// File: rtl/sms_delay_line.sv
// Fixed-depth shift pipeline carrying one bit per channel.
// Latency: exactly DELAY clocks from din to dout.
// Backpressure: none; advances every clock, async reset empties all stages.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : WIDTH-bit value entering stage 0
//   dout       : WIDTH-bit value of the last stage
module sms_delay_line #(
  parameter int WIDTH = 4,
  parameter int DELAY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stg [DELAY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= din;
      for (int i = 1; i < DELAY; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign dout = stg[DELAY-1];

endmodule

// File: rtl/sms_inv_bank.sv
// Bank of 2-input inverter / binary-trigger channels with a delayed output.
// Latency: DELAY clocks from gate inputs to y and dot_or; out_valid after DELAY clocks of reset release.
// Backpressure: none; every clock advances the pipeline unconditionally.
//
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   in_a, in_b  : per-channel gate inputs, read through a pull-up (z = 1, x = 0)
//   mode        : per-channel mode, 0 = inverter, 1 = binary trigger
//   trig_clr    : synchronous clear of every trigger state, beats a toggle
//   y           : delayed channel values; OC_MASK channels drive 1 or z
//   dot_or      : OR of the delayed channel values (ignores OC_MASK)
//   out_valid   : pipeline has filled since the last reset
//   float_seen  : sticky per-channel z-input flags when built with
//                 SMS_INV_BANK_FLOAT_CHECK_EN, otherwise constant 0
module sms_inv_bank
  import sms_pkg::*;
#(
  parameter int                  CHANNELS = 4,
  parameter int                  DELAY    = 2,
  parameter logic [CHANNELS-1:0] OC_MASK  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in_a,
  input  logic [CHANNELS-1:0] in_b,
  input  logic [CHANNELS-1:0] mode,
  input  logic                trig_clr,
  output logic [CHANNELS-1:0] y,
  output logic                dot_or,
  output logic                out_valid,
  output logic [CHANNELS-1:0] float_seen
);

  localparam int CNT_W = $clog2(SMS_DELAY_MAX + 1);

  logic [CHANNELS-1:0] g;
  logic [CHANNELS-1:0] g_q;
  logic [CHANNELS-1:0] t;
  logic [CHANNELS-1:0] t_d;
  logic [CHANNELS-1:0] trig_sel;
  logic [CHANNELS-1:0] v;
  logic [CHANNELS-1:0] last;
  logic [CNT_W-1:0]    fill_cnt;

  // Gate: a channel is active when either input reads low.
  always_comb begin
    g        = '0;
    trig_sel = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      g[n]        = ~ipu(in_a[n]) | ~ipu(in_b[n]);
      trig_sel[n] = (mode[n] == SMS_MODE_TRIG);
    end
  end

  // Trigger next state: toggles only on a rising gate edge in trigger
  // mode, so inverter-mode channels keep their trigger state untouched.
  // The clear is applied last so it wins over a coincident toggle.
  always_comb begin
    t_d = t ^ (g & ~g_q & trig_sel);
    if (trig_clr) begin
      t_d = '0;
    end
  end

  // The trigger value entering the pipeline is the post-edge state, so a
  // toggle shows up on y the same DELAY clocks after its edge as an
  // inverter change does.
  always_comb begin
    v = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      v[n] = trig_sel[n] ? t_d[n] : g[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q <= '0;
      t   <= '0;
    end else begin
      g_q <= g;
      t   <= t_d;
    end
  end

  sms_delay_line #(
    .WIDTH (CHANNELS),
    .DELAY (DELAY)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (v),
    .dout  (last)
  );

  // Fill counter saturates at DELAY; it only restarts on reset, which is
  // also the only event that empties the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
    end else if (fill_cnt != CNT_W'(DELAY)) begin
      fill_cnt <= fill_cnt + CNT_W'(1);
    end
  end

  assign out_valid = (fill_cnt == CNT_W'(DELAY));
  assign dot_or    = |last;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_out
    if (OC_MASK[n]) begin : g_oc
      assign y[n] = last[n] ? 1'b1 : 1'bz;
    end else begin : g_pp
      assign y[n] = last[n];
    end
  end

`ifdef SMS_INV_BANK_FLOAT_CHECK_EN
  logic [CHANNELS-1:0] z_in;
  logic [CHANNELS-1:0] float_q;

  always_comb begin
    z_in = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      z_in[n] = is_z(in_a[n]) | is_z(in_b[n]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      float_q <= '0;
    end else begin
      float_q <= float_q | z_in;
    end
  end

  assign float_seen = float_q;
`else
  assign float_seen = '0;
`endif

endmodule

// File: tb/tb_sms_inv_bank.sv
// Self-checking bench for sms_inv_bank (CHANNELS=4, DELAY=2, OC_MASK=4'b1000).
// Directed vector table, hand-written reset / floating-input sequences,
// then randomized stimulus against a queue-based reference model.
module tb_sms_inv_bank;

  localparam int         CH  = 4;
  localparam int         DLY = 2;
  localparam logic [3:0] OC  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_a, in_b, mode;
  logic       trig_clr;
  logic [3:0] y;
  logic       dot_or, out_valid;
  logic [3:0] float_seen;

  always #5 clk = ~clk;

  sms_inv_bank #(
    .CHANNELS (CH),
    .DELAY    (DLY),
    .OC_MASK  (OC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_a       (in_a),
    .in_b       (in_b),
    .mode       (mode),
    .trig_clr   (trig_clr),
    .y          (y),
    .dot_or     (dot_or),
    .out_valid  (out_valid),
    .float_seen (float_seen)
  );

  int checks   = 0;
  int failures = 0;
  bit four_state;

  // Input levels as codes: 0 = 0, 1 = 1, 2 = z, 3 = x.
  int a_code [CH];
  int b_code [CH];

  // Reference model state.
  bit [3:0] t_m, gp_m, flt_m;
  bit [3:0] pipe_q [$];
  int       fill_m;

`ifdef SMS_INV_BANK_FLOAT_CHECK_EN
  localparam bit FLOAT_EN = 1'b1;
`else
  localparam bit FLOAT_EN = 1'b0;
`endif

  function automatic logic code_val(input int c);
    case (c)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'bz;
      default: return 1'bx;
    endcase
  endfunction

  function automatic bit pulled_high(input int c);
    return (c == 1) || (c == 2);
  endfunction

  task automatic drive();
    for (int n = 0; n < CH; n++) begin
      in_a[n] = code_val(a_code[n]);
      in_b[n] = code_val(b_code[n]);
    end
  endtask

  task automatic set_bits(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] m, input logic c);
    for (int n = 0; n < CH; n++) begin
      a_code[n] = a[n] ? 1 : 0;
      b_code[n] = b[n] ? 1 : 0;
    end
    mode     = m;
    trig_clr = c;
    drive();
  endtask

  task automatic model_reset();
    t_m    = '0;
    gp_m   = '0;
    flt_m  = '0;
    fill_m = 0;
    pipe_q.delete();
    for (int i = 0; i < DLY; i++) pipe_q.push_back(4'b0000);
  endtask

  task automatic model_step();
    bit [3:0] gv, vv;
    for (int n = 0; n < CH; n++) begin
      gv[n] = !pulled_high(a_code[n]) || !pulled_high(b_code[n]);
      if (trig_clr)
        t_m[n] = 1'b0;
      else if (mode[n] && gv[n] && !gp_m[n])
        t_m[n] = ~t_m[n];
      vv[n] = mode[n] ? t_m[n] : gv[n];
      if (a_code[n] == 2 || b_code[n] == 2) flt_m[n] = 1'b1;
    end
    gp_m = gv;
    pipe_q.push_back(vv);
    void'(pipe_q.pop_front());
    if (fill_m < DLY) fill_m++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic chk_y(input string nm, input logic [3:0] stage);
    bit ok = 1'b1;
    for (int n = 0; n < CH; n++) begin
      if (OC[n] && !stage[n]) begin
        if (four_state) begin
          if (y[n] !== 1'bz) ok = 1'b0;
        end else if (y[n] === 1'b1) begin
          ok = 1'b0;
        end
      end else if (y[n] !== stage[n]) begin
        ok = 1'b0;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s y: got %b, want stage %b (OC mask %b gives z for 0)", nm, y, stage, OC);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string nm);
    bit [3:0] s;
    s = pipe_q[0];
    chk_y(nm, s);
    chk_bit({nm, " dot_or"}, dot_or, |s);
    chk_bit({nm, " out_valid"}, out_valid, fill_m == DLY);
    chk_vec({nm, " float_seen"}, float_seen, FLOAT_EN ? flt_m : 4'b0000);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] m;
    logic       c;
    logic [3:0] stg;
    logic       dot;
    logic       vld;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic probe;
    probe      = 1'bz;
    four_state = (probe !== 1'b0) && (probe !== 1'b1);

    //              a        b        mode     clr   stage    dot   vld
    tbl[0]  = '{4'b1110, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 4'b0111, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1};
    tbl[2]  = '{4'b1111, 4'b1111, 4'b0100, 1'b0, 4'b1000, 1'b1, 1'b1};
    tbl[3]  = '{4'b1011, 4'b1111, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[4]  = '{4'b1011, 4'b1111, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1};
    tbl[5]  = '{4'b1111, 4'b1111, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1};
    tbl[6]  = '{4'b1011, 4'b1111, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1};
    tbl[7]  = '{4'b1111, 4'b1111, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[8]  = '{4'b1011, 4'b1111, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[9]  = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1};
    tbl[10] = '{4'b1111, 4'b1111, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[11] = '{4'b1011, 4'b1111, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1};
    tbl[12] = '{4'b1111, 4'b1111, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1};

    // Reset state.
    rst_n = 1'b0;
    set_bits(4'b1111, 4'b1111, 4'b0000, 1'b0);
    model_reset();
    #1;
    chk_y("reset", 4'b0000);
    chk_bit("reset dot_or", dot_or, 1'b0);
    chk_bit("reset out_valid", out_valid, 1'b0);
    chk_vec("reset float_seen", float_seen, 4'b0000);
    tick();
    tick();
    chk_bit("held reset out_valid", out_valid, 1'b0);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      set_bits(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].c);
      tick();
      chk_y($sformatf("tbl%0d", i), tbl[i].stg);
      chk_bit($sformatf("tbl%0d dot_or", i), dot_or, tbl[i].dot);
      chk_bit($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].vld);
    end

    // Reset pulse while y = 1010, then refill.
    set_bits(4'b0101, 4'b1111, 4'b0000, 1'b0);
    tick();
    tick();
    chk_y("pre-reset", 4'b1010);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk_y("mid reset", 4'b0000);
    chk_bit("mid reset dot_or", dot_or, 1'b0);
    chk_bit("mid reset out_valid", out_valid, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    chk_bit("refill 1 out_valid", out_valid, 1'b0);
    chk_y("refill 1", 4'b0000);
    tick();
    chk_bit("refill 2 out_valid", out_valid, 1'b1);
    chk_y("refill 2", 4'b1010);

    // Floating and unknown inputs (needs a four-state simulator).
    if (four_state) begin
      set_bits(4'b1111, 4'b1111, 4'b0000, 1'b0);
      a_code[0] = 3;
      a_code[1] = 2;
      b_code[1] = 2;
      drive();
      tick();
      tick();
      chk_y("x/z inputs", 4'b0001);
      chk_vec("float set", float_seen, FLOAT_EN ? 4'b0010 : 4'b0000);
      set_bits(4'b1111, 4'b1111, 4'b0000, 1'b0);
      tick();
      tick();
      tick();
      chk_vec("float sticky", float_seen, FLOAT_EN ? 4'b0010 : 4'b0000);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk_vec("float reset", float_seen, 4'b0000);
      #1 rst_n = 1'b1;
    end

    // Randomized run against the reference model.
    mode = 4'($urandom);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 149) == 0) begin
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk_model($sformatf("rnd%0d in reset", cyc));
        #1 rst_n = 1'b1;
      end
      for (int n = 0; n < CH; n++) begin
        int r;
        r = $urandom_range(0, 7);
        a_code[n] = (r < 4) ? 1 : (r < 6) ? 0 : (r == 6) ? (four_state ? 2 : 1) : (four_state ? 3 : 0);
        r = $urandom_range(0, 7);
        b_code[n] = (r < 5) ? 1 : (r < 7) ? 0 : (four_state ? 2 : 1);
      end
      drive();
      if ($urandom_range(0, 7) == 0) mode = 4'($urandom);
      trig_clr = ($urandom_range(0, 11) == 0);
      tick();
      chk_model($sformatf("rnd%0d", cyc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sms_inv_bank.md
SMS_INV_BANK -- requirements
Module: sms_inv_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of 2-way inverter channels, range 1..16.
REQ-002 SHALL have parameter DELAY, default 2: clocks from gate input to y, range 1..8.
REQ-003 SHALL have parameter OC_MASK, default 0 (CHANNELS bits): a 1 in bit n makes channel n an open-collector output.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_a, input, CHANNELS bits: gate input A per channel; z reads as 1 (pull-up).
REQ-007 SHALL have port in_b, input, CHANNELS bits: gate input B per channel; z reads as 1.
REQ-008 SHALL have port mode, input, CHANNELS bits: 0 = inverter, 1 = binary trigger.
REQ-009 SHALL have port trig_clr, input, 1 bit: synchronous clear of all trigger states.
REQ-010 SHALL have port y, output, CHANNELS bits: delayed channel output.
REQ-011 SHALL have port dot_or, output, 1 bit: OR of all delayed channel values.
REQ-012 SHALL have port out_valid, output, 1 bit: pipeline has filled since the last reset.
REQ-013 SHALL have port float_seen, output, CHANNELS bits: sticky floating-input flags.

Function
REQ-014 Pull-up read SHALL be ipu(x) = 1 for x = 1 or z, and 0 otherwise (0 or x).
REQ-015 Gate value per channel SHALL be g[n] = !ipu(in_a[n]) | !ipu(in_b[n]).
REQ-016 Each channel SHALL register g[n] every cycle into g_q[n].
REQ-017 Inverter mode: channel value v[n] SHALL equal g[n].
REQ-018 Trigger mode: t[n] SHALL toggle on the cycle where g[n]=1 and g_q[n]=0; v[n] SHALL equal t[n].
REQ-019 trig_clr=1 SHALL set every t[n]=0 that cycle; clear SHALL win over a simultaneous toggle.
REQ-020 A mode change SHALL NOT alter t[n]; t[n] SHALL hold while the channel is in inverter mode.
REQ-021 v SHALL pass through a DELAY-stage shift pipeline; y[n] SHALL be the last stage, so an input change reaches y exactly DELAY clocks later.
REQ-022 An OC channel SHALL drive y[n]=1 when its stage value is 1 and z when it is 0; other channels SHALL drive 0/1.
REQ-023 dot_or SHALL be the OR of the last-stage values, independent of OC_MASK.
REQ-024 A fill counter SHALL count 0..DELAY after reset, saturate at DELAY, and out_valid SHALL be 1 only when the count equals DELAY.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear g_q, t, all pipeline stages, the fill counter and float_seen.
REQ-026 During reset: y = 0 (z on OC channels), dot_or = 0, out_valid = 0.
REQ-027 Reset asserted mid-operation SHALL discard in-flight pipeline data; out_valid SHALL return after DELAY clocks following deassertion.

Configuration
REQ-028 Macro SMS_INV_BANK_FLOAT_CHECK_EN defined: float_seen[n] SHALL set on any clock where in_a[n] or in_b[n] is z, and clear only on reset.
REQ-029 Macro undefined: float_seen SHALL be constant 0 and SHALL infer no flops.

Structure
REQ-030 Package sms_pkg SHALL hold the ipu function, the mode encodings SMS_MODE_INV=0 and SMS_MODE_TRIG=1, and the constant SMS_DELAY_MAX=8.
REQ-031 Sub-module sms_delay_line SHALL implement the per-channel DELAY-stage pipeline, with fill-counter logic kept in the parent.

Verification
REQ-032 CHANNELS=4, DELAY=2, mode=0: set in_a[0]=0 at cycle 10 -> y[0]=1 at cycle 12 and dot_or=1 at cycle 12.
REQ-033 in_a[1]=z and in_b[1]=z -> y[1]=0; with the macro defined, float_seen[1]=1 and stays 1 until reset.
REQ-034 mode[2]=1, three 0->1 edges of g[2] -> y[2] sequence 1,0,1, each DELAY clocks after its edge; trig_clr coincident with the 4th edge -> y[2]=0.
REQ-035 OC_MASK=4'b1000, channel 3 values 0 then 1 -> y[3]=z, then 1.
REQ-036 Pulse rst_n low at cycle 20 while y=4'b1010 -> y=0 and out_valid=0 immediately; out_valid=1 exactly 2 clocks after release.
REQ-037 in_a[0]=x -> read as 0, so y[0]=1 after DELAY clocks.
